// File: rtl/tone_sequencer.sv
// Programmable (freq, duration) tone scheduler feeding a square-wave generator's freq input.
// Build macro TONE_SEQ_GAP_EN inserts a silent PRESCALE-cycle gap after every played entry that is followed by a load.
module tone_sequencer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DUR_W    = 12,
  parameter int unsigned PRESCALE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [7:0]               wr_freq,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic [$clog2(DEPTH):0]   num_entries,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic [7:0]               freq_out,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic                     done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned FW = 8;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
`ifdef TONE_SEQ_GAP_EN
  localparam logic [2:0] S_GAP  = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic             start_q, start_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    n_q, n_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [FW-1:0]    freq_q, freq_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [FW-1:0]    tbl_freq_q [DEPTH];
  logic [FW-1:0]    tbl_freq_d [DEPTH];
  logic [DUR_W-1:0] tbl_dur_q  [DEPTH];
  logic [DUR_W-1:0] tbl_dur_d  [DEPTH];

  logic [NW-1:0]    n_eff;
  logic             is_last;
  logic             adv_load;
  logic [AW-1:0]    adv_idx;
  logic             pre_wrap;
  logic [FW-1:0]    ent_freq;
  logic [DUR_W-1:0] ent_dur;

  // Host table writes land on the edge; playback only sees them at the next LOAD.
  always_comb begin
    tbl_freq_d = tbl_freq_q;
    tbl_dur_d  = tbl_dur_q;
    if (wr_en) begin
      tbl_freq_d[wr_addr] = wr_freq;
      tbl_dur_d[wr_addr]  = wr_dur;
    end
  end

  assign ent_freq = tbl_freq_q[idx_q];
  assign ent_dur  = tbl_dur_q[idx_q];
  assign n_eff    = (num_entries > NW'(DEPTH)) ? NW'(DEPTH) : num_entries;
  assign pre_wrap = (pre_q == PW'(PRESCALE - 1));

  // Where playback goes after the current entry finishes or is skipped.
  always_comb begin
    is_last  = (NW'(idx_q) + NW'(1)) >= n_q;
    adv_idx  = idx_q + AW'(1);
    adv_load = 1'b1;
    if (is_last) begin
      adv_load = loop_en;
      adv_idx  = loop_en ? '0 : idx_q;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start & ~stop & (state_q == S_IDLE);
    idx_d   = idx_q;
    n_d     = n_q;
    pre_d   = pre_q;
    dur_d   = dur_q;
    freq_d  = freq_q;

    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          n_d     = n_eff;
          idx_d   = '0;
          state_d = (n_eff == '0) ? S_FIN : S_LOAD;
        end
      end

      S_LOAD: begin
        if (ent_dur != '0) begin
          state_d = S_PLAY;
          freq_d  = ent_freq;
          dur_d   = ent_dur;
          pre_d   = '0;
        end else begin
          idx_d   = adv_idx;
          state_d = adv_load ? S_LOAD : S_FIN;
        end
      end

      S_PLAY: begin
        if (pre_wrap) begin
          pre_d = '0;
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) begin
            idx_d = adv_idx;
            if (!adv_load) begin
              state_d = S_FIN;
            end else begin
`ifdef TONE_SEQ_GAP_EN
              state_d = S_GAP;
              freq_d  = '0;
`else
              state_d = S_LOAD;
`endif
            end
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end

`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        if (pre_wrap) begin
          pre_d   = '0;
          state_d = S_LOAD;
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
`endif

      S_FIN: begin
        freq_d  = '0;
        state_d = S_IDLE;
      end

      default: begin
        freq_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything except reset and never produces a done pulse.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      freq_d  = '0;
      idx_d   = '0;
      pre_d   = '0;
      dur_d   = '0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      idx_q      <= '0;
      n_q        <= '0;
      pre_q      <= '0;
      dur_q      <= '0;
      freq_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tbl_freq_q <= '{default: '0};
      tbl_dur_q  <= '{default: '0};
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      pre_q      <= pre_d;
      dur_q      <= dur_d;
      freq_q     <= freq_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tbl_freq_q <= tbl_freq_d;
      tbl_dur_q  <= tbl_dur_d;
    end
  end

  assign freq_out = freq_q;
  assign busy     = busy_q;
  assign cur_idx  = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: directed scenario table, hand-written corner sequences,
// and randomized tables checked cycle by cycle against a schedule model built from the entry list.
module tb_tone_sequencer;

  localparam int DEPTH = 8;
  localparam int DUR_W = 12;
  localparam int P     = 16;
`ifdef TONE_SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif
  localparam int G = GAP ? P : 0;

  logic             clk;
  logic             rst_n;
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [7:0]       wr_freq;
  logic [DUR_W-1:0] wr_dur;
  logic [3:0]       num_entries;
  logic             loop_en;
  logic             start;
  logic             stop;
  logic [7:0]       freq_out;
  logic             busy;
  logic [2:0]       cur_idx;
  logic             done;

  int checks;
  int errors;

  int tbl_f [DEPTH];
  int tbl_d [DEPTH];

  typedef struct {
    int f;
    bit b;
    bit d;
    bit iv;
    int ci;
  } exp_t;

  exp_t exp_q [$];

  typedef struct {
    int f0; int d0; int f1; int d1; int f2; int d2;
    int num;
    int probe_c;
    int probe_f;
    int done_c;
    int done_c_gap;
  } vec_t;

  vec_t vecs [6];

  int f_hist [0:160];
  int b_hist [0:160];

  tone_sequencer #(.DEPTH(DEPTH), .DUR_W(DUR_W), .PRESCALE(P)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_freq    (wr_freq),
    .wr_dur     (wr_dur),
    .num_entries(num_entries),
    .loop_en    (loop_en),
    .start      (start),
    .stop       (stop),
    .freq_out   (freq_out),
    .busy       (busy),
    .cur_idx    (cur_idx),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input string what, input int cyc, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s.%s cyc=%0d actual=%0d expected=%0d", nm, what, cyc, act, exp_v);
    end
  endtask

  task automatic wr(input int a, input int f, input int d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_freq = 8'(f);
    wr_dur  = DUR_W'(d);
    tick();
    wr_en   = 1'b0;
    tbl_f[a] = f;
    tbl_d[a] = d;
  endtask

  function automatic void push(input int f, input bit b, input bit d, input bit iv, input int ci);
    exp_t e;
    e.f  = f;
    e.b  = b;
    e.d  = d;
    e.iv = iv;
    e.ci = ci;
    exp_q.push_back(e);
  endfunction

  // Expected per-cycle outputs from cycle 1 after the start edge, derived from the entry list.
  task automatic build_model(input int n_cfg, input bit lp, input int limit);
    int n;
    int v;
    int idx;
    int cur;
    exp_q.delete();
    n   = (n_cfg > DEPTH) ? DEPTH : n_cfg;
    cur = 0;
    v   = 0;
    if (n == 0) begin
      push(0, 1'b1, 1'b1, 1'b0, 0);
      push(0, 1'b0, 1'b0, 1'b0, 0);
      return;
    end
    while (exp_q.size() < limit) begin
      idx = v % n;
      if (!lp && (v == n)) begin
        push(cur, 1'b1, 1'b1, 1'b0, 0);
        push(0, 1'b0, 1'b0, 1'b0, 0);
        break;
      end
      push(cur, 1'b1, 1'b0, 1'b1, idx);
      if (tbl_d[idx] != 0) begin
        cur = tbl_f[idx];
        for (int k = 0; k < tbl_d[idx] * P; k++) push(cur, 1'b1, 1'b0, 1'b1, idx);
        if (GAP && (lp || (idx < n - 1))) begin
          cur = 0;
          for (int k = 0; k < P; k++) push(0, 1'b1, 1'b0, 1'b0, 0);
        end
      end
      v++;
    end
  endtask

  task automatic run_cmp(input string nm, input int n_cfg, input bit lp, input int limit);
    build_model(n_cfg, lp, limit);
    num_entries = 4'(n_cfg);
    loop_en     = lp;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    chk(nm, "busy", 0, int'(busy), 0);
    chk(nm, "freq", 0, int'(freq_out), 0);
    foreach (exp_q[i]) begin
      tick();
      chk(nm, "freq", i + 1, int'(freq_out), exp_q[i].f);
      chk(nm, "busy", i + 1, int'(busy), int'(exp_q[i].b));
      chk(nm, "done", i + 1, int'(done), int'(exp_q[i].d));
      if (exp_q[i].iv) chk(nm, "cur_idx", i + 1, int'(cur_idx), exp_q[i].ci);
    end
    if (lp) begin
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk(nm, "stop_freq", 0, int'(freq_out), 0);
      chk(nm, "stop_busy", 0, int'(busy), 0);
      chk(nm, "stop_done", 0, int'(done), 0);
      chk(nm, "stop_idx", 0, int'(cur_idx), 0);
    end
  endtask

  initial begin
    int pf;
    int dc;
    int bl;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_dur = '0;
    num_entries = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin tbl_f[a] = 0; tbl_d[a] = 0; end

    vecs[0] = '{10, 3, 20, 2, 0, 0, 2, 30, 10, 83, 99};
    vecs[1] = '{5, 1, 7, 0, 9, 1, 3, 10, 5, 36, 52};
    vecs[2] = '{1, 1, 2, 2, 3, 3, 0, 1, 0, 1, 1};
    vecs[3] = '{40, 2, 0, 0, 0, 0, 1, 20, 40, 34, 34};
    vecs[4] = '{0, 2, 8, 1, 0, 0, 2, 2, 0, 51, 67};
    vecs[5] = '{200, 1, 0, 0, 0, 0, 3, 17, 200, 20, 36};

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    chk("reset", "freq", 0, int'(freq_out), 0);
    chk("reset", "busy", 0, int'(busy), 0);
    chk("reset", "done", 0, int'(done), 0);
    chk("reset", "cur_idx", 0, int'(cur_idx), 0);

    // Reset with start held must clear the table and not launch playback
    wr(0, 77, 5);
    rst_n = 1'b0;
    start = 1'b1;
    num_entries = 4'd1;
    tick(); tick();
    chk("rst_start", "freq", 0, int'(freq_out), 0);
    chk("rst_start", "busy", 0, int'(busy), 0);
    chk("rst_start", "done", 0, int'(done), 0);
    rst_n = 1'b1;
    start = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin tbl_f[a] = 0; tbl_d[a] = 0; end
    tick(); tick();
    chk("rst_start", "busy_after", 0, int'(busy), 0);
    run_cmp("rst_readback", 1, 1'b0, 100000);

    // Directed scenario table
    for (int vi = 0; vi < 6; vi++) begin
      wr(0, vecs[vi].f0, vecs[vi].d0);
      wr(1, vecs[vi].f1, vecs[vi].d1);
      wr(2, vecs[vi].f2, vecs[vi].d2);
      num_entries = 4'(vecs[vi].num);
      loop_en = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      pf = -1;
      dc = -1;
      bl = -1;
      for (int c = 1; c <= 400; c++) begin
        tick();
        if (c == vecs[vi].probe_c) pf = int'(freq_out);
        if (dc >= 0) begin
          bl = int'(busy);
          chk("vec", "done_width", vi, int'(done), 0);
          break;
        end
        if (done) dc = c;
      end
      chk("vec", "done_cycle", vi, dc, GAP ? vecs[vi].done_c_gap : vecs[vi].done_c);
      chk("vec", "probe_freq", vi, pf, vecs[vi].probe_f);
      chk("vec", "busy_after", vi, bl, 0);
      chk("vec", "freq_after", vi, int'(freq_out), 0);
    end

    // Skip and loop, then stop mid-entry
    wr(0, 5, 1); wr(1, 7, 0); wr(2, 9, 1);
    run_cmp("skip_loop", 3, 1'b1, 150);

    // Count above DEPTH clamps to all entries
    for (int a = 0; a < DEPTH; a++) wr(a, a * 3 + 1, 1 + (a % 2));
    run_cmp("clamp12", 12, 1'b0, 100000);

    // Writes during playback and ignored start while busy
    wr(0, 10, 4); wr(1, 50, 2);
    num_entries = 4'd2;
    loop_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      tick();
      f_hist[c] = int'(freq_out);
      b_hist[c] = int'(busy);
      case (c)
        10: begin wr_en = 1'b1; wr_addr = 3'd1; wr_freq = 8'd33; wr_dur = DUR_W'(1); end
        11: begin wr_addr = 3'd0; wr_freq = 8'd99; wr_dur = DUR_W'(1); end
        12: wr_en = 1'b0;
        20: start = 1'b1;
        21: start = 1'b0;
        default: ;
      endcase
    end
    tbl_f[0] = 99; tbl_d[0] = 1; tbl_f[1] = 33; tbl_d[1] = 1;
    chk("wr_play", "freq", 40, f_hist[40], 10);
    chk("wr_play", "freq", 65, f_hist[65], 10);
    chk("wr_play", "freq", 75 + G, f_hist[75 + G], 33);
    chk("wr_play", "freq", 84 + 2 * G, f_hist[84 + 2 * G], 99);
    chk("wr_play", "freq", 99 + 2 * G, f_hist[99 + 2 * G], 99);
    chk("wr_play", "freq", 101 + 2 * G, f_hist[101 + 2 * G], GAP ? 0 : 33);
    chk("wr_play", "busy", 30, b_hist[30], 1);
    chk("wr_play", "busy", 140, b_hist[140], 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("wr_play", "stop_busy", 0, int'(busy), 0);
    chk("wr_play", "stop_freq", 0, int'(freq_out), 0);

    // Start and stop together: stop wins
    num_entries = 4'd2;
    loop_en = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    chk("start_stop", "busy", 1, int'(busy), 0);
    tick();
    chk("start_stop", "busy", 2, int'(busy), 0);
    chk("start_stop", "done", 2, int'(done), 0);

    // Randomized tables against the schedule model
    for (int it = 0; it < 20; it++) begin
      for (int a = 0; a < DEPTH; a++) wr(a, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      if ((it % 4) == 3) run_cmp("rnd_loop", int'($urandom_range(1, 8)), 1'b1, int'($urandom_range(20, 200)));
      else run_cmp("rnd", int'($urandom_range(0, 10)), 1'b0, 100000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Programmable tone scheduler that drives the 8-bit `freq` input of the square-wave generator.
- Holds a small table of (freq, duration) entries, written by a host.
- On `start`, plays the entries in order, presenting each freq for its programmed duration.
- Supports single-shot or looping playback.
- `freq_out` = 0 means silence, since the generator holds its output when freq is zero.

Parameters:
- DEPTH, 8: number of table entries; power of 2, 2..16.
- DUR_W, 12: width of each entry's duration field, in ticks.
- PRESCALE, 16: clock cycles per duration tick; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  table write strobe.
- wr_addr  in  clog2(DEPTH)  table write index.
- wr_freq  in  8  freq value for the written entry.
- wr_dur  in  DUR_W  duration of the written entry, in ticks.
- num_entries  in  clog2(DEPTH)+1  entries to play; clamped to DEPTH.
- loop_en  in  1  1 = restart at entry 0 after the last entry.
- start  in  1  begin playback; level sampled each cycle.
- stop  in  1  abort playback.
- freq_out  out  8  freq fed to the square-wave generator.
- busy  out  1  high in any state other than IDLE.
- cur_idx  out  clog2(DEPTH)  index of the entry being loaded or played.
- done  out  1  one-cycle pulse when single-shot playback completes.

Behaviour:
Clock and reset
- Single clock `clk`; reset is synchronous and active-low (`rst_n`).
- `rst_n` = 0 at a clock edge forces state IDLE and clears every table entry to freq 0, dur 0.
- Reset values: freq_out = 0, busy = 0, cur_idx = 0, done = 0; all internal counters = 0.
- Reset dominates any other input, including mid-playback.

Table writes
- `wr_en` writes the entry at `wr_addr` on the clock edge, in any state.
- A write takes effect the next time that entry is loaded. An entry already playing is unaffected.

State machine: IDLE -> LOAD -> PLAY -> (LOAD | FIN) -> IDLE
- IDLE:
  - `start` = 1 with effective count N >= 1 (N = min(num_entries, DEPTH)): go to LOAD, cur_idx = 0.
  - `start` = 1 with N = 0: go to FIN; nothing is played.
- LOAD (1 cycle): read entry[cur_idx].
  - dur != 0: go to PLAY; freq_out <= entry freq; load the duration counter; clear the prescaler.
  - dur == 0: skip the entry with freq_out unchanged; advance as described under "Advance".
- PLAY:
  - The prescaler counts 0..PRESCALE-1; each wrap is one tick and decrements the duration counter.
  - When a tick brings the counter to 0, advance.
  - An entry with duration D therefore occupies exactly D*PRESCALE PLAY cycles plus 1 LOAD cycle.
- Advance:
  - cur_idx < N-1: cur_idx + 1, go to LOAD.
  - Last entry with loop_en = 1: cur_idx = 0, go to LOAD.
  - Last entry with loop_en = 0: go to FIN.
  - `loop_en` is sampled at the advance decision.
- FIN (1 cycle): freq_out <= 0, done = 1, then IDLE.

Stop and start rules
- `stop` = 1 in any non-IDLE state: next state IDLE, freq_out <= 0, cur_idx <= 0, no done pulse.
- `stop` and `start` asserted together: stop wins.
- `start` is ignored while busy.
- `num_entries` is sampled only when leaving IDLE.
- With loop_en = 1 and all N entries at dur 0, the block cycles through LOAD indefinitely with busy = 1 until `stop`. This is legal.

Output timing
- `start` seen at edge k: LOAD during cycle k+1; freq_out valid from edge k+2.
- `busy` is high from edge k+1 until the return to IDLE.

Optional Feature:
TONE_SEQ_GAP_EN
- Defined: a GAP state is inserted before every LOAD that follows a completed PLAY, including a loop restart.
  - GAP holds freq_out = 0 for exactly PRESCALE cycles.
  - `stop` is honoured in GAP.
  - Skipped (dur 0) entries do not add a gap.
- Not defined: no GAP state exists, and entries follow back-to-back as described above.

Test Plan:
- Reset with defaults: rst_n low 2 cycles, start pulsed during reset -> freq_out = 0, busy = 0, done = 0, and a later readback play of any entry shows freq 0 / dur 0 (entries were cleared).
- Entry0 = (10, 3), entry1 = (20, 2), N = 2, loop_en = 0, start at edge 0:
  - freq_out = 10 for cycles 2..49 (48 cycles).
  - Cycle 50 is LOAD with freq_out still 10.
  - freq_out = 20 for cycles 51..82.
  - FIN at cycle 83 with done = 1; freq_out = 0 from edge 84; busy low from edge 84.
- Skip and loop: entry0 = (5, 1), entry1 = (7, 0), entry2 = (9, 1), N = 3, loop_en = 1:
  - freq_out sequence is 5, 9, 5, 9, ...; 7 is never driven; cur_idx visits 1 only for one LOAD cycle.
  - done never pulses.
  - stop asserted mid-entry -> next cycle freq_out = 0, busy = 0, no done.
- N = 0 and N = 12 with DEPTH = 8:
  - N = 0: start gives done one cycle later and freq_out stays 0.
  - N = 12: plays exactly 8 entries, then done.
- Write during play: while entry0 (10, 4) is playing, write entry1 = (33, 1) and entry0 = (99, 1):
  - Entry1 plays 33.
  - On loop_en = 1 restart, entry0 plays 99 for 16 cycles.
  - start pulses while busy have no effect.
- With TONE_SEQ_GAP_EN, rerun the second scenario: freq_out = 0 for 16 cycles between the 10 and 20 segments, and done lands 16 cycles later (cycle 99).
